// File: rtl/aes_round_sequencer_pkg.sv
// Shared types and defaults for the AES round-timing sequencer.
// The round count comes from the NUM_ROUNDS macro and falls back to 10 (AES-128).
`ifndef NUM_ROUNDS
`define NUM_ROUNDS 10
`endif

package AESDefinitions;

    localparam int AES_NUM_ROUNDS = `NUM_ROUNDS;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        ROUNDS = 3'd2,
        FINAL  = 3'd3,
        DONE   = 3'd4
    } seq_state_t;

    typedef enum logic [1:0] {
        RT_NONE    = 2'd0,
        RT_INITIAL = 2'd1,
        RT_MIDDLE  = 2'd2,
        RT_FINAL   = 2'd3
    } round_type_t;

endpackage

// File: rtl/aes_round_sequencer_index_counter.sv
// Round index counter: synchronous clear and increment, saturating at MAX_VALUE.
// count_next exposes the value the counter will load, so dependent registers can stay in step with it.
module aes_round_index_counter #(
    parameter int IDX_WIDTH = 4,
    parameter int MAX_VALUE = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 incr,
    output logic [IDX_WIDTH-1:0] count,
    output logic [IDX_WIDTH-1:0] count_next
);

    localparam logic [IDX_WIDTH-1:0] MAX_IDX = IDX_WIDTH'(MAX_VALUE);

    logic [IDX_WIDTH-1:0] count_q;
    logic [IDX_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (incr && (count_q != MAX_IDX)) begin
            count_d = count_q + IDX_WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count      = count_q;
    assign count_next = count_d;

endmodule

// File: rtl/aes_round_sequencer.sv
// Issuing side of the AES round-timing interface: one block per start handshake, done handshake at the end.
// Optional feature macro ROUND_SEQ_ABORT_EN adds an abort input that cancels a block in flight.
module aes_round_sequencer
    import AESDefinitions::*;
#(
    parameter int NUM_ROUNDS = AES_NUM_ROUNDS,
    parameter int IDX_WIDTH  = $clog2(NUM_ROUNDS + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic                 decrypt,
    output logic                 round_en,
    output round_type_t          round_type,
    output logic [IDX_WIDTH-1:0] round_idx,
    output logic [IDX_WIDTH-1:0] key_idx,
    output logic                 busy,
    output logic                 done_valid,
    input  logic                 done_ready
`ifdef ROUND_SEQ_ABORT_EN
    ,
    input  logic                 abort
`endif
);

    if (NUM_ROUNDS < 2) begin : g_bad_rounds
        $error("aes_round_sequencer: NUM_ROUNDS must be at least 2");
    end

    localparam logic [IDX_WIDTH-1:0] NR_IDX          = IDX_WIDTH'(NUM_ROUNDS);
    localparam logic [IDX_WIDTH-1:0] LAST_MIDDLE_IDX = IDX_WIDTH'(NUM_ROUNDS - 1);

    seq_state_t           state_q, state_d;
    logic                 dir_q, dir_d;
    logic                 round_en_q, round_en_d;
    round_type_t          round_type_q, round_type_d;
    logic [IDX_WIDTH-1:0] key_idx_q, key_idx_d;
    logic                 busy_q, busy_d;
    logic                 done_valid_q, done_valid_d;

    logic                 cnt_clear;
    logic                 cnt_incr;
    logic [IDX_WIDTH-1:0] cnt_value;
    logic [IDX_WIDTH-1:0] cnt_next;
    logic                 abort_req;

`ifdef ROUND_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // An abort request in IDLE blocks new work, so the start handshake is held off as well.
    assign start_ready = (state_q == IDLE) && !reset && !abort_req;

    aes_round_index_counter #(
        .IDX_WIDTH (IDX_WIDTH),
        .MAX_VALUE (NUM_ROUNDS)
    ) u_round_counter (
        .clock      (clock),
        .reset      (reset),
        .clear      (cnt_clear),
        .incr       (cnt_incr),
        .count      (cnt_value),
        .count_next (cnt_next)
    );

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        cnt_clear = 1'b0;
        cnt_incr  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_valid && start_ready) begin
                    state_d   = INIT;
                    dir_d     = decrypt;
                    cnt_clear = 1'b1;
                end
            end
            INIT: begin
                state_d  = ROUNDS;
                cnt_incr = 1'b1;
            end
            ROUNDS: begin
                cnt_incr = 1'b1;
                if (cnt_value == LAST_MIDDLE_IDX) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                state_d = DONE;
            end
            DONE: begin
                if (done_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A cancelled block leaves every output at its reset value, including the direction.
        if (abort_req && ((state_q == INIT) || (state_q == ROUNDS) || (state_q == FINAL))) begin
            state_d   = IDLE;
            dir_d     = 1'b0;
            cnt_clear = 1'b1;
            cnt_incr  = 1'b0;
        end

        round_en_d   = (state_d == INIT) || (state_d == ROUNDS) || (state_d == FINAL);
        busy_d       = (state_d != IDLE);
        done_valid_d = (state_d == DONE);
        key_idx_d    = dir_d ? (NR_IDX - cnt_next) : cnt_next;

        case (state_d)
            INIT:    round_type_d = RT_INITIAL;
            ROUNDS:  round_type_d = RT_MIDDLE;
            FINAL:   round_type_d = RT_FINAL;
            default: round_type_d = RT_NONE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            dir_q        <= 1'b0;
            round_en_q   <= 1'b0;
            round_type_q <= RT_NONE;
            key_idx_q    <= '0;
            busy_q       <= 1'b0;
            done_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            round_en_q   <= round_en_d;
            round_type_q <= round_type_d;
            key_idx_q    <= key_idx_d;
            busy_q       <= busy_d;
            done_valid_q <= done_valid_d;
        end
    end

    assign round_en   = round_en_q;
    assign round_type = round_type_q;
    assign round_idx  = cnt_value;
    assign key_idx    = key_idx_q;
    assign busy       = busy_q;
    assign done_valid = done_valid_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed self-checking bench for aes_round_sequencer with the default 10-round build.
// Define ROUND_SEQ_ABORT_EN for both bench and RTL to exercise the abort input.
module tb_aes_round_sequencer;

    localparam int NR = 10;

    logic       clock;
    logic       reset;
    logic       start_valid;
    logic       start_ready;
    logic       decrypt;
    logic       round_en;
    logic [1:0] round_type;
    logic [3:0] round_idx;
    logic [3:0] key_idx;
    logic       busy;
    logic       done_valid;
    logic       done_ready;
    logic       abort;

    int check_count;
    int error_count;
    int done_count;

    aes_round_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .decrypt     (decrypt),
        .round_en    (round_en),
        .round_type  (round_type),
        .round_idx   (round_idx),
        .key_idx     (key_idx),
        .busy        (busy),
        .done_valid  (done_valid),
        .done_ready  (done_ready)
`ifdef ROUND_SEQ_ABORT_EN
        ,
        .abort       (abort)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic sv, input logic dec, input logic dr);
        start_valid = sv;
        decrypt     = dec;
        done_ready  = dr;
    endtask

    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " busy"}, 32'(busy), 0);
        checkOutput({tag, " round_en"}, 32'(round_en), 0);
        checkOutput({tag, " round_type"}, 32'(round_type), 0);
        checkOutput({tag, " done_valid"}, 32'(done_valid), 0);
    endtask

    // Accept one block, walk the rounds, optionally toggling decrypt each cycle, then complete it.
    task automatic runBlock(input logic dec, input logic toggle, input string tag);
        logic [1:0] exp_type;
        logic       dec_now;
        dec_now = dec;
        applyStimulus(1'b1, dec_now, 1'b0);
        #1;
        checkOutput({tag, " start_ready"}, 32'(start_ready), 1);
        stepCycle();
        applyStimulus(1'b0, dec_now, 1'b0);
        for (int k = 0; k <= NR; k++) begin
            exp_type = (k == 0) ? 2'd1 : ((k == NR) ? 2'd3 : 2'd2);
            checkOutput($sformatf("%s round_idx[%0d]", tag, k), 32'(round_idx), 32'(k));
            checkOutput($sformatf("%s key_idx[%0d]", tag, k), 32'(key_idx), dec ? 32'(NR - k) : 32'(k));
            checkOutput($sformatf("%s round_type[%0d]", tag, k), 32'(round_type), 32'(exp_type));
            checkOutput($sformatf("%s round_en[%0d]", tag, k), 32'(round_en), 1);
            checkOutput($sformatf("%s done_valid[%0d]", tag, k), 32'(done_valid), 0);
            if (toggle) begin
                dec_now = ~dec_now;
                decrypt = dec_now;
            end
            stepCycle();
        end
        checkOutput({tag, " done_valid"}, 32'(done_valid), 1);
        checkOutput({tag, " done round_en"}, 32'(round_en), 0);
        checkOutput({tag, " done round_type"}, 32'(round_type), 0);
        checkOutput({tag, " done round_idx"}, 32'(round_idx), 32'(NR));
        applyStimulus(1'b0, 1'b0, 1'b1);
        stepCycle();
        checkOutput({tag, " post busy"}, 32'(busy), 0);
        checkOutput({tag, " post done_valid"}, 32'(done_valid), 0);
        checkOutput({tag, " post start_ready"}, 32'(start_ready), 1);
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        check_count = 0;
        error_count = 0;
        reset       = 1'b1;
        abort       = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        stepCycle();
        stepCycle();

        checkIdle("reset");
        checkOutput("reset round_idx", 32'(round_idx), 0);
        checkOutput("reset key_idx", 32'(key_idx), 0);
        checkOutput("reset start_ready", 32'(start_ready), 0);
        reset = 1'b0;
        #1;
        checkOutput("release start_ready", 32'(start_ready), 1);
        stepCycle();

        $display("[TB] encrypt block");
        runBlock(1'b0, 1'b0, "enc");

        $display("[TB] decrypt block with decrypt toggling mid-block");
        runBlock(1'b1, 1'b1, "dec");

        $display("[TB] done back-pressure with start_valid held high");
        applyStimulus(1'b1, 1'b0, 1'b0);
        stepCycle();
        for (int k = 0; k <= NR; k++) stepCycle();
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("hold done_valid[%0d]", i), 32'(done_valid), 1);
            checkOutput($sformatf("hold round_en[%0d]", i), 32'(round_en), 0);
            checkOutput($sformatf("hold start_ready[%0d]", i), 32'(start_ready), 0);
            stepCycle();
        end
        done_ready = 1'b1;
        stepCycle();
        done_ready = 1'b0;
        checkOutput("handshake busy", 32'(busy), 0);
        checkOutput("handshake done_valid", 32'(done_valid), 0);
        checkOutput("handshake start_ready", 32'(start_ready), 1);
        stepCycle();
        checkOutput("second accept busy", 32'(busy), 1);
        checkOutput("second accept round_type", 32'(round_type), 1);
        checkOutput("second accept round_idx", 32'(round_idx), 0);
        start_valid = 1'b0;
        for (int k = 0; k <= NR; k++) stepCycle();
        checkOutput("second block done_valid", 32'(done_valid), 1);
        done_ready = 1'b1;
        stepCycle();
        done_ready = 1'b0;
        checkOutput("second block idle", 32'(busy), 0);

        $display("[TB] reset in the middle of a block");
        applyStimulus(1'b1, 1'b1, 1'b0);
        stepCycle();
        start_valid = 1'b0;
        for (int k = 0; k < 4; k++) stepCycle();
        checkOutput("pre-reset round_idx", 32'(round_idx), 4);
        reset = 1'b1;
        stepCycle();
        checkIdle("mid reset");
        checkOutput("mid reset round_idx", 32'(round_idx), 0);
        checkOutput("mid reset key_idx", 32'(key_idx), 0);
        checkOutput("mid reset start_ready", 32'(start_ready), 0);
        reset = 1'b0;
        #1;
        checkOutput("after reset start_ready", 32'(start_ready), 1);
        done_count = 0;
        done_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            stepCycle();
            if (done_valid) done_count++;
        end
        done_ready = 1'b0;
        checkOutput("no done after reset", 32'(done_count), 0);

        $display("[TB] start pulses while busy");
        applyStimulus(1'b1, 1'b0, 1'b1);
        stepCycle();
        done_count = 0;
        for (int i = 0; i < 25; i++) begin
            start_valid = busy && ((i % 3) == 0);
            stepCycle();
            if (done_valid) done_count++;
        end
        start_valid = 1'b0;
        done_ready  = 1'b0;
        checkOutput("one done per start", 32'(done_count), 1);
        checkOutput("pulses end idle", 32'(busy), 0);

`ifdef ROUND_SEQ_ABORT_EN
        $display("[TB] abort at round 7 and abort in IDLE");
        applyStimulus(1'b1, 1'b1, 1'b0);
        stepCycle();
        start_valid = 1'b0;
        for (int k = 0; k < 7; k++) stepCycle();
        checkOutput("pre-abort round_idx", 32'(round_idx), 7);
        checkOutput("pre-abort key_idx", 32'(key_idx), 3);
        abort = 1'b1;
        stepCycle();
        abort = 1'b0;
        checkIdle("abort");
        checkOutput("abort round_idx", 32'(round_idx), 0);
        checkOutput("abort key_idx", 32'(key_idx), 0);
        done_count = 0;
        done_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            stepCycle();
            if (done_valid) done_count++;
        end
        done_ready = 1'b0;
        checkOutput("no done after abort", 32'(done_count), 0);
        abort       = 1'b1;
        start_valid = 1'b1;
        #1;
        checkOutput("abort idle start_ready", 32'(start_ready), 0);
        stepCycle();
        checkOutput("abort idle busy", 32'(busy), 0);
        abort       = 1'b0;
        start_valid = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
